// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle RV32I control unit and its datapath/memory.
// master: the control unit; slave: the datapath side that supplies IR fields and flags.
interface multicycle_control_unit_if #(
    parameter int unsigned ALU_CTRL_W = 4
);
    logic [6:0]            op_i;
    logic [2:0]            funct3_i;
    logic                  funct7_i;
    logic                  Zero_i;
    logic                  Lt_i;
    logic                  Ltu_i;
    logic                  mem_ready_i;
    logic                  mem_req_o;
    logic                  MemWrite_o;
    logic                  AdrSrc_o;
    logic                  IRWrite_o;
    logic                  PCWrite_o;
    logic                  RegWrite_o;
    logic [1:0]            ALUSrcA_o;
    logic [1:0]            ALUSrcB_o;
    logic [1:0]            ResultSrc_o;
    logic [2:0]            ImmSrc_o;
    logic [ALU_CTRL_W-1:0] ALUControl_o;
    logic                  illegal_o;
    logic [3:0]            state_o;

    modport master (
        input  op_i, funct3_i, funct7_i, Zero_i, Lt_i, Ltu_i, mem_ready_i,
        output mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
               ALUSrcA_o, ALUSrcB_o, ResultSrc_o, ImmSrc_o, ALUControl_o, illegal_o, state_o
    );

    modport slave (
        output op_i, funct3_i, funct7_i, Zero_i, Lt_i, Ltu_i, mem_ready_i,
        input  mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
               ALUSrcA_o, ALUSrcB_o, ResultSrc_o, ImmSrc_o, ALUControl_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (fetch/decode/execute/memory/writeback, shared ALU and memory).
// Define CU_ILLEGAL_TRAP_EN to park illegal instructions in TRAP instead of treating them as NOPs.
module multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input logic                       clk_i,
    input logic                       rst_i,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        StFetch   = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRead = 4'd3,
        StMemWb   = 4'd4,  StMemWrite = 4'd5, StExecR = 4'd6,  StExecI   = 4'd7,
        StAluWb   = 4'd8,  StBranch = 4'd9,  StJal    = 4'd10, StJalr    = 4'd11,
        StJalrPc  = 4'd12, StLui    = 4'd13, StAuipc  = 4'd14, StTrap    = 4'd15
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;

    state_e state_q, state_d;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_op, funct_alu;
    logic       known_op, legal, taken;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        unique case (bus.op_i)
            OpLoad, OpStore, OpR, OpImm, OpBranch, OpJal, OpJalr, OpLui, OpAuipc: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
        // Branch funct3 010/011 do not exist in RV32I.
        legal = known_op && !(bus.op_i == OpBranch && bus.funct3_i[2:1] == 2'b01);
    end

    always_comb begin
        unique case (bus.op_i)
            OpStore:        imm_src = 3'b010;
            OpBranch:       imm_src = 3'b001;
            OpLui, OpAuipc: imm_src = 3'b011;
            OpJal:          imm_src = 3'b100;
            default:        imm_src = 3'b000;
        endcase
    end

    always_comb begin
        unique case (bus.funct3_i)
            3'b000:  funct_alu = (bus.funct7_i && bus.op_i[5]) ? AluSub : AluAdd;
            3'b001:  funct_alu = 4'b0111;
            3'b010:  funct_alu = 4'b0101;
            3'b011:  funct_alu = 4'b0110;
            3'b100:  funct_alu = 4'b0100;
            3'b101:  funct_alu = bus.funct7_i ? 4'b1001 : 4'b1000;
            3'b110:  funct_alu = 4'b0011;
            default: funct_alu = 4'b0010;
        endcase
    end

    always_comb begin
        case (bus.funct3_i)
            3'b000:  taken = bus.Zero_i;
            3'b001:  taken = !bus.Zero_i;
            3'b100:  taken = bus.Lt_i;
            3'b101:  taken = !bus.Lt_i;
            3'b110:  taken = bus.Ltu_i;
            3'b111:  taken = !bus.Ltu_i;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = AluAdd;
        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (bus.mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (!legal) begin
                    illegal = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    state_d = StFetch;
`endif
                end else begin
                    unique case (bus.op_i)
                        OpLoad, OpStore: state_d = StMemAdr;
                        OpR:             state_d = StExecR;
                        OpImm:           state_d = StExecI;
                        OpBranch:        state_d = StBranch;
                        OpJal:           state_d = StJal;
                        OpJalr:          state_d = StJalr;
                        OpLui:           state_d = StLui;
                        OpAuipc:         state_d = StAuipc;
                        default:         state_d = StFetch;
                    endcase
                end
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op_i == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready_i) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready_i) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = funct_alu;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = funct_alu;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                alu_op    = AluSub;
                pc_write  = taken;
                state_d   = StFetch;
            end
            StJal, StJalrPc: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StJalr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = StJalrPc;
            end
            StLui: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = StAluWb;
            end
            StAuipc: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = StAluWb;
            end
            StTrap: begin
                illegal = 1'b1;
                state_d = StTrap;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset forces every output low, which also drops an in-flight memory request at once.
    assign bus.mem_req_o    = !rst_i && mem_req;
    assign bus.MemWrite_o   = !rst_i && mem_write;
    assign bus.AdrSrc_o     = !rst_i && adr_src;
    assign bus.IRWrite_o    = !rst_i && ir_write;
    assign bus.PCWrite_o    = !rst_i && pc_write;
    assign bus.RegWrite_o   = !rst_i && reg_write;
    assign bus.illegal_o    = !rst_i && illegal;
    assign bus.ALUSrcA_o    = rst_i ? 2'b00 : alu_src_a;
    assign bus.ALUSrcB_o    = rst_i ? 2'b00 : alu_src_b;
    assign bus.ResultSrc_o  = rst_i ? 2'b00 : result_src;
    assign bus.ImmSrc_o     = rst_i ? 3'b000 : imm_src;
    assign bus.ALUControl_o = rst_i ? '0 : ALU_CTRL_W'(alu_op);
    assign bus.state_o      = rst_i ? 4'd0 : state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
// Honours CU_ILLEGAL_TRAP_EN to check the trap build as well as the default NOP build.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus ();

    multicycle_control_unit #(.ALU_CTRL_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op_i     = op;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(7'b0100011, 3'b010, 1'b1);
        bus.mem_ready_i = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.mem_req_o, bus.MemWrite_o, bus.AdrSrc_o, bus.IRWrite_o, bus.PCWrite_o,
             bus.RegWrite_o, bus.illegal_o} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b exp=0000000", {bus.mem_req_o, bus.MemWrite_o,
                     bus.AdrSrc_o, bus.IRWrite_o, bus.PCWrite_o, bus.RegWrite_o, bus.illegal_o});
        end
        n_cmp++;
        if ({bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ResultSrc_o, bus.ImmSrc_o, bus.ALUControl_o,
             bus.state_o} !== 17'b0) begin
            n_err++;
            $display("FAIL reset_sel got=%b exp=0", {bus.ALUSrcA_o, bus.ALUSrcB_o,
                     bus.ResultSrc_o, bus.ImmSrc_o, bus.ALUControl_o, bus.state_o});
        end
        bus.mem_ready_i = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.state_o, bus.mem_req_o, bus.AdrSrc_o, bus.ALUSrcB_o, bus.ResultSrc_o,
             bus.IRWrite_o, bus.ImmSrc_o} !== {4'd0, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 3'b010}) begin
            n_err++;
            $display("FAIL fetch_wait got=%h exp=%h", {bus.state_o, bus.mem_req_o, bus.AdrSrc_o,
                     bus.ALUSrcB_o, bus.ResultSrc_o, bus.IRWrite_o, bus.ImmSrc_o},
                     {4'd0, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 3'b010});
        end
        step();
        n_cmp++;
        if (bus.state_o !== 4'd0) begin
            n_err++;
            $display("FAIL fetch_hold got=%0d exp=0", bus.state_o);
        end
    endtask

    task automatic test_addi();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        set_instr(7'b0010011, 3'b000, 1'b0);
        bus.mem_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.state_o !== exp_st[i]) begin
                n_err++;
                $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, bus.state_o, exp_st[i]);
            end
            n_cmp++;
            if ({bus.IRWrite_o, bus.PCWrite_o, bus.RegWrite_o} !==
                {(i == 0 || i == 4), (i == 0 || i == 4), (i == 3)}) begin
                n_err++;
                $display("FAIL addi_writes[%0d] got=%b", i,
                         {bus.IRWrite_o, bus.PCWrite_o, bus.RegWrite_o});
            end
            if (i == 2) begin
                n_cmp++;
                if ({bus.ALUControl_o, bus.ALUSrcA_o, bus.ALUSrcB_o} !== 8'b0000_10_01) begin
                    n_err++;
                    $display("FAIL addi_exec got=%b exp=00001001",
                             {bus.ALUControl_o, bus.ALUSrcA_o, bus.ALUSrcB_o});
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_load_wait();
        set_instr(7'b0000011, 3'b010, 1'b0);
        step();
        step();
        bus.mem_ready_i = 1'b0;
        n_cmp++;
        if ({bus.state_o, bus.ALUSrcA_o, bus.ALUSrcB_o} !== {4'd2, 2'b10, 2'b01}) begin
            n_err++;
            $display("FAIL load_memadr got=%b", {bus.state_o, bus.ALUSrcA_o, bus.ALUSrcB_o});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) bus.mem_ready_i = 1'b1;
            n_cmp++;
            if ({bus.state_o, bus.mem_req_o, bus.AdrSrc_o, bus.MemWrite_o, bus.IRWrite_o} !==
                {4'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL load_wait[%0d] got=%b exp=00111100", i, {bus.state_o,
                         bus.mem_req_o, bus.AdrSrc_o, bus.MemWrite_o, bus.IRWrite_o});
            end
        end
        step();
        n_cmp++;
        if ({bus.state_o, bus.ResultSrc_o, bus.RegWrite_o, bus.mem_req_o} !==
            {4'd4, 2'b01, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL load_memwb got=%b exp=01000110",
                     {bus.state_o, bus.ResultSrc_o, bus.RegWrite_o, bus.mem_req_o});
        end
        step();
        n_cmp++;
        if (bus.state_o !== 4'd0) begin
            n_err++;
            $display("FAIL load_done got=%0d exp=0", bus.state_o);
        end
    endtask

    task automatic test_store();
        set_instr(7'b0100011, 3'b010, 1'b0);
        step();
        step();
        step();
        n_cmp++;
        if ({bus.state_o, bus.mem_req_o, bus.MemWrite_o, bus.AdrSrc_o, bus.ImmSrc_o} !==
            {4'd5, 3'b111, 3'b010}) begin
            n_err++;
            $display("FAIL store_write got=%b exp=0101111010", {bus.state_o, bus.mem_req_o,
                     bus.MemWrite_o, bus.AdrSrc_o, bus.ImmSrc_o});
        end
        step();
        n_cmp++;
        if (bus.state_o !== 4'd0) begin
            n_err++;
            $display("FAIL store_done got=%0d exp=0", bus.state_o);
        end
    endtask

    task automatic test_branch();
        // funct3, Zero, Lt, Ltu, taken
        logic [6:0] vec [6] = '{
            {3'b100, 1'b0, 1'b1, 1'b0, 1'b1},  // BLT taken
            {3'b111, 1'b0, 1'b0, 1'b1, 1'b0},  // BGEU not taken (rs1 <u rs2)
            {3'b111, 1'b0, 1'b0, 1'b0, 1'b1},  // BGEU taken
            {3'b001, 1'b0, 1'b0, 1'b0, 1'b1},  // BNE taken
            {3'b000, 1'b0, 1'b0, 1'b0, 1'b0},  // BEQ not taken
            {3'b101, 1'b1, 1'b1, 1'b0, 1'b0}   // BGE not taken
        };
        logic [6:0] v;
        for (int i = 0; i < 6; i++) begin
            v = vec[i];
            set_instr(7'b1100011, v[6:4], 1'b0);
            {bus.Zero_i, bus.Lt_i, bus.Ltu_i} = v[3:1];
            step();
            step();
            n_cmp++;
            if ({bus.state_o, bus.PCWrite_o, bus.ALUControl_o, bus.ALUSrcA_o, bus.ImmSrc_o} !==
                {4'd9, v[0], 4'b0001, 2'b10, 3'b001}) begin
                n_err++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, {bus.state_o, bus.PCWrite_o,
                         bus.ALUControl_o, bus.ALUSrcA_o, bus.ImmSrc_o},
                         {4'd9, v[0], 4'b0001, 2'b10, 3'b001});
            end
            bus.mem_ready_i = 1'b0;
            step();
            n_cmp++;
            if ({bus.state_o, bus.PCWrite_o} !== {4'd0, 1'b0}) begin
                n_err++;
                $display("FAIL branch_ret[%0d] got=%b exp=00000",
                         i, {bus.state_o, bus.PCWrite_o});
            end
            bus.mem_ready_i = 1'b1;
        end
        {bus.Zero_i, bus.Lt_i, bus.Ltu_i} = 3'b000;
    endtask

    task automatic test_jumps();
        logic [3:0] jalr_st [4] = '{4'd11, 4'd12, 4'd8, 4'd0};
        logic [3:0] jal_st  [3] = '{4'd10, 4'd8, 4'd0};
        set_instr(7'b1100111, 3'b000, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({bus.state_o, bus.PCWrite_o, bus.RegWrite_o} !==
                {jalr_st[i], (i == 1 || i == 3), (i == 2)}) begin
                n_err++;
                $display("FAIL jalr[%0d] got=%b exp=%b", i, {bus.state_o, bus.PCWrite_o,
                         bus.RegWrite_o}, {jalr_st[i], (i == 1 || i == 3), (i == 2)});
            end
        end
        set_instr(7'b1101111, 3'b000, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus.state_o, bus.PCWrite_o, bus.RegWrite_o} !==
                {jal_st[i], (i != 1), (i == 1)}) begin
                n_err++;
                $display("FAIL jal[%0d] got=%b exp=%b", i, {bus.state_o, bus.PCWrite_o,
                         bus.RegWrite_o}, {jal_st[i], (i != 1), (i == 1)});
            end
        end
    endtask

    task automatic test_alu_decode();
        // op, funct3, funct7, exec state, ALU control
        logic [18:0] vec [7] = '{
            {7'b0010011, 3'b101, 1'b1, 4'd7, 4'b1001},  // SRAI
            {7'b0110011, 3'b000, 1'b1, 4'd6, 4'b0001},  // SUB
            {7'b0010011, 3'b000, 1'b1, 4'd7, 4'b0000},  // ADDI, bit30 ignored
            {7'b0110011, 3'b011, 1'b0, 4'd6, 4'b0110},  // SLTU
            {7'b0110011, 3'b111, 1'b0, 4'd6, 4'b0010},  // AND
            {7'b0110011, 3'b101, 1'b0, 4'd6, 4'b1000},  // SRL
            {7'b0010011, 3'b001, 1'b0, 4'd7, 4'b0111}   // SLLI
        };
        logic [18:0] v;
        for (int i = 0; i < 7; i++) begin
            v = vec[i];
            set_instr(v[18:12], v[11:9], v[8]);
            step();
            step();
            n_cmp++;
            if ({bus.state_o, bus.ALUControl_o} !== v[7:0]) begin
                n_err++;
                $display("FAIL alu_dec[%0d] got=%b exp=%b", i,
                         {bus.state_o, bus.ALUControl_o}, v[7:0]);
            end
            step();
            step();
        end
    endtask

    task automatic test_upper();
        set_instr(7'b0110111, 3'b000, 1'b0);
        step();
        step();
        n_cmp++;
        if ({bus.state_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ImmSrc_o} !==
            {4'd13, 2'b11, 2'b01, 3'b011}) begin
            n_err++;
            $display("FAIL lui got=%b", {bus.state_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ImmSrc_o});
        end
        step();
        step();
        set_instr(7'b0010111, 3'b000, 1'b0);
        step();
        step();
        n_cmp++;
        if ({bus.state_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ImmSrc_o} !==
            {4'd14, 2'b01, 2'b01, 3'b011}) begin
            n_err++;
            $display("FAIL auipc got=%b",
                     {bus.state_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ImmSrc_o});
        end
        step();
        step();
        n_cmp++;
        if (bus.state_o !== 4'd0) begin
            n_err++;
            $display("FAIL auipc_done got=%0d exp=0", bus.state_o);
        end
    endtask

    task automatic test_reset_mid_read();
        set_instr(7'b0000011, 3'b000, 1'b0);
        step();
        step();
        bus.mem_ready_i = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.state_o, bus.mem_req_o, bus.AdrSrc_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_abort got=%b exp=000000",
                     {bus.state_o, bus.mem_req_o, bus.AdrSrc_o});
        end
        step();
        rst = 1'b0;
        bus.mem_ready_i = 1'b1;
        #1;
    endtask

    task automatic test_illegal();
        logic [9:0] vec [2] = '{{7'b0000000, 3'b000}, {7'b1100011, 3'b010}};
        for (int i = 0; i < 2; i++) begin
            set_instr(vec[i][9:3], vec[i][2:0], 1'b0);
            step();
            n_cmp++;
            if ({bus.state_o, bus.illegal_o, bus.RegWrite_o, bus.PCWrite_o} !=
                {4'd1, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL illegal_dec[%0d] got=%b exp=0001100", i,
                         {bus.state_o, bus.illegal_o, bus.RegWrite_o, bus.PCWrite_o});
            end
`ifdef CU_ILLEGAL_TRAP_EN
            for (int k = 0; k < 3; k++) begin
                step();
                n_cmp++;
                if ({bus.state_o, bus.illegal_o, bus.mem_req_o, bus.RegWrite_o, bus.PCWrite_o,
                     bus.IRWrite_o} !== {4'd15, 5'b10000}) begin
                    n_err++;
                    $display("FAIL trap_hold[%0d] got=%b exp=111110000", k, {bus.state_o,
                             bus.illegal_o, bus.mem_req_o, bus.RegWrite_o, bus.PCWrite_o,
                             bus.IRWrite_o});
                end
            end
            rst = 1'b1;
            #1;
            n_cmp++;
            if ({bus.state_o, bus.illegal_o} !== 5'b0) begin
                n_err++;
                $display("FAIL trap_reset got=%b exp=00000", {bus.state_o, bus.illegal_o});
            end
            step();
            rst = 1'b0;
            #1;
`else
            step();
            n_cmp++;
            if ({bus.state_o, bus.illegal_o} !== 5'b0) begin
                n_err++;
                $display("FAIL illegal_nop[%0d] got=%b exp=00000", i,
                         {bus.state_o, bus.illegal_o});
            end
`endif
        end
    endtask

    initial begin
        {bus.Zero_i, bus.Lt_i, bus.Ltu_i, bus.mem_ready_i} = 4'b0000;
        rst = 1'b1;
        set_instr(7'b0, 3'b0, 1'b0);
        test_reset();
        test_addi();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps();
        test_alu_decode();
        test_upper();
        test_reset_mid_read();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
